// File: rtl/mod_sub_fix_4_parts_if.sv
`default_nettype none
// ============================================================================
// Module      : mod_sub_fix_4_parts_if
// Description : Handshake/data bundle between the staged 4-part subtractor
//               and its modular correction stage.
//               start  - upstream requests a correction run
//               diff   - signed SIZE+1-bit difference a-b (bit SIZE = sign)
//               p      - field modulus
//               result - canonical (a-b) mod p
//               done   - 1 = idle / result valid, 0 = busy
// Revision    : 1.0 - initial release
// ============================================================================
interface mod_sub_fix_4_parts_if #(
   parameter int SIZE = 448
);
   logic            start;
   logic [SIZE:0]   diff;
   logic [SIZE-1:0] p;
   logic [SIZE-1:0] result;
   logic            done;

   // Upstream side: drives the request and operands, observes the result.
   modport master (
      output start,
      output diff,
      output p,
      input  result,
      input  done
   );

   // Correction stage side.
   modport slave (
      input  start,
      input  diff,
      input  p,
      output result,
      output done
   );
endinterface
`default_nettype wire

// File: rtl/mod_sub_fix_4_parts.sv
`default_nettype none
// ============================================================================
// Module      : mod_sub_fix_4_parts
// Description : Correction stage following the staged 4-part subtractor.
//               When the incoming difference is negative, the modulus p is
//               added back in four quarter-width additions (one per clock),
//               giving the canonical field element (a-b) mod p.
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset
//               bus    - slave side of mod_sub_fix_4_parts_if
//                        (start/diff/p in, result/done out)
// Revision    : 1.0 - initial release
// ============================================================================
module mod_sub_fix_4_parts #(
   parameter int SIZE = 448
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   mod_sub_fix_4_parts_if.slave   bus
);

   localparam int Q = SIZE / 4;

   localparam logic [1:0] c_idle   = 2'd0;
   localparam logic [1:0] c_stage1 = 2'd1;
   localparam logic [1:0] c_stage2 = 2'd2;
   localparam logic [1:0] c_stage3 = 2'd3;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;

   // Upper three quarters of the operands, held for stages 1..3 so the
   // upstream is free to change diff/p after the start cycle. The sign is
   // not kept separately: it is already folded into the latched addend.
   logic [SIZE-Q-1:0] r_dq;
   logic [SIZE-Q-1:0] r_aq;
   logic              r_carry;
   logic [Q-1:0]      r_part0;
   logic [Q-1:0]      r_part1;
   logic [Q-1:0]      r_part2;
   logic [SIZE-1:0]   r_result;
   logic              r_done;

   logic [SIZE-1:0]   w_addend;
   logic [Q-1:0]      w_op_d;
   logic [Q-1:0]      w_op_a;
   logic              w_cin;
   logic [Q:0]        w_sum;
   logic              w_capture;
   logic              w_step1;
   logic              w_step2;
   logic              w_finish;

   assign w_addend = bus.diff[SIZE] ? bus.p : '0;

   // One shared quarter-width adder; the operand quarter is chosen by state.
   assign w_sum = {1'b0, w_op_d} + {1'b0, w_op_a} + {{Q{1'b0}}, w_cin};

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic: start only matters in IDLE, busy states advance
   // unconditionally.
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_idle:   if (bus.start) w_state_nxt = c_stage1;
         c_stage1: w_state_nxt = c_stage2;
         c_stage2: w_state_nxt = c_stage3;
         c_stage3: w_state_nxt = c_idle;
         default:  w_state_nxt = c_idle;
      endcase
   end

   // ------------------------------------------------------------------
   // Output / control decode
   // ------------------------------------------------------------------
   always_comb begin
      w_capture = 1'b0;
      w_step1   = 1'b0;
      w_step2   = 1'b0;
      w_finish  = 1'b0;
      w_op_d    = bus.diff[Q-1:0];
      w_op_a    = w_addend[Q-1:0];
      w_cin     = 1'b0;
      case (r_state)
         c_idle: begin
            w_capture = bus.start;
         end
         c_stage1: begin
            w_step1 = 1'b1;
            w_op_d  = r_dq[Q-1:0];
            w_op_a  = r_aq[Q-1:0];
            w_cin   = r_carry;
         end
         c_stage2: begin
            w_step2 = 1'b1;
            w_op_d  = r_dq[2*Q-1:Q];
            w_op_a  = r_aq[2*Q-1:Q];
            w_cin   = r_carry;
         end
         c_stage3: begin
            w_finish = 1'b1;
            w_op_d   = r_dq[3*Q-1:2*Q];
            w_op_a   = r_aq[3*Q-1:2*Q];
            w_cin    = r_carry;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dq     <= '0;
         r_aq     <= '0;
         r_carry  <= 1'b0;
         r_part0  <= '0;
         r_part1  <= '0;
         r_part2  <= '0;
         r_result <= '0;
         r_done   <= 1'b1;
      end else begin
         if (w_capture) begin
            r_dq               <= bus.diff[SIZE-1:Q];
            r_aq               <= w_addend[SIZE-1:Q];
            {r_carry, r_part0} <= w_sum;
            r_done             <= 1'b0;
         end
         if (w_step1) begin
            {r_carry, r_part1} <= w_sum;
         end
         if (w_step2) begin
            {r_carry, r_part2} <= w_sum;
         end
         if (w_finish) begin
            // Top-quarter carry is dropped: the negative case wraps mod 2^SIZE.
            r_result <= {w_sum[Q-1:0], r_part2, r_part1, r_part0};
            r_carry  <= 1'b0;
            r_done   <= 1'b1;
         end
      end
   end

   assign bus.result = r_result;
   assign bus.done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mod_sub_fix_4_parts.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_sub_fix_4_parts
// Description : Directed self-checking bench for mod_sub_fix_4_parts with
//               SIZE=448 and p = 2^448 - 2^224 - 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_sub_fix_4_parts;

   localparam int SIZE = 448;

   logic clk;
   logic rst_n;

   int n_tests;
   int n_fail;

   logic [SIZE-1:0] p_val;
   logic [SIZE-1:0] pm1;
   logic [SIZE:0]   neg1;
   logic [SIZE:0]   negpm1;

   mod_sub_fix_4_parts_if #(.SIZE(SIZE)) bus ();

   mod_sub_fix_4_parts #(.SIZE(SIZE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [SIZE-1:0] obs, input logic [SIZE-1:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge. Issues one start, scrambles the operands
   // afterwards, checks done is low for three cycles, then checks the result.
   task automatic run_op(input string tag, input logic [SIZE:0] d, input logic [SIZE-1:0] exp);
      bus.start = 1'b1;
      bus.diff  = d;
      bus.p     = p_val;
      @(negedge clk);
      bus.start = 1'b0;
      bus.diff  = ~d;
      bus.p     = '0;
      chk({tag, "_busy0"}, {{(SIZE-1){1'b0}}, bus.done}, '0);
      @(negedge clk);
      chk({tag, "_busy1"}, {{(SIZE-1){1'b0}}, bus.done}, '0);
      @(negedge clk);
      chk({tag, "_busy2"}, {{(SIZE-1){1'b0}}, bus.done}, '0);
      @(negedge clk);
      chk({tag, "_done"}, {{(SIZE-1){1'b0}}, bus.done}, {{(SIZE-1){1'b0}}, 1'b1});
      chk({tag, "_result"}, bus.result, exp);
      bus.p = p_val;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;

      p_val      = {SIZE{1'b1}};
      p_val[224] = 1'b0;
      pm1        = p_val - 1'b1;
      neg1       = {(SIZE+1){1'b1}};
      negpm1     = ~{1'b0, pm1} + 1'b1;

      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.diff  = '0;
      bus.p     = p_val;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("reset_done", {{(SIZE-1){1'b0}}, bus.done}, {{(SIZE-1){1'b0}}, 1'b1});
      chk("reset_result", bus.result, '0);
      rst_n = 1'b1;
      @(negedge clk);

      // Positive, negative full carry chain, large negative, zero
      run_op("pos5",  {{(SIZE-2){1'b0}}, 3'd5}, {{(SIZE-3){1'b0}}, 3'd5});
      run_op("neg1",  neg1, pm1);
      run_op("negpm1", negpm1, {{(SIZE-1){1'b0}}, 1'b1});
      run_op("zero",  '0, '0);

      // Start pulsed while busy is ignored
      bus.start = 1'b1;
      bus.diff  = neg1;
      @(negedge clk);                  // edge 0 captured
      bus.diff  = {{(SIZE-2){1'b0}}, 3'd7};
      @(negedge clk);                  // edge 1, start high while busy
      chk("busy_ign_b1", {{(SIZE-1){1'b0}}, bus.done}, '0);
      @(negedge clk);                  // edge 2, start high while busy
      bus.start = 1'b0;
      chk("busy_ign_b2", {{(SIZE-1){1'b0}}, bus.done}, '0);
      @(negedge clk);                  // edge 3
      chk("busy_ign_done", {{(SIZE-1){1'b0}}, bus.done}, {{(SIZE-1){1'b0}}, 1'b1});
      chk("busy_ign_result", bus.result, pm1);
      @(negedge clk);
      chk("busy_ign_norun", {{(SIZE-1){1'b0}}, bus.done}, {{(SIZE-1){1'b0}}, 1'b1});
      chk("busy_ign_hold", bus.result, pm1);

      // Reset mid-operation (during STAGE2)
      bus.start = 1'b1;
      bus.diff  = neg1;
      @(negedge clk);                  // edge 0 -> STAGE1
      bus.start = 1'b0;
      @(negedge clk);                  // edge 1 -> STAGE2
      rst_n = 1'b0;
      #1;
      chk("rst_mid_done", {{(SIZE-1){1'b0}}, bus.done}, {{(SIZE-1){1'b0}}, 1'b1});
      chk("rst_mid_result", bus.result, '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op("after_rst3", {{(SIZE-1){1'b0}}, 2'd3}, {{(SIZE-2){1'b0}}, 2'd3});

      // Back-to-back with start held high
      bus.start = 1'b1;
      bus.diff  = neg1;
      @(negedge clk);                  // edge N: first run captured
      bus.diff  = {{(SIZE-3){1'b0}}, 4'd9};
      chk("b2b_busy0", {{(SIZE-1){1'b0}}, bus.done}, '0);
      @(negedge clk);
      chk("b2b_busy1", {{(SIZE-1){1'b0}}, bus.done}, '0);
      @(negedge clk);
      chk("b2b_busy2", {{(SIZE-1){1'b0}}, bus.done}, '0);
      @(negedge clk);                  // edge N+3: first result
      chk("b2b_done1", {{(SIZE-1){1'b0}}, bus.done}, {{(SIZE-1){1'b0}}, 1'b1});
      chk("b2b_result1", bus.result, pm1);
      @(negedge clk);                  // edge N+4: second run captured
      bus.start = 1'b0;
      chk("b2b_busy3", {{(SIZE-1){1'b0}}, bus.done}, '0);
      chk("b2b_hold", bus.result, pm1);
      @(negedge clk);
      chk("b2b_busy4", {{(SIZE-1){1'b0}}, bus.done}, '0);
      @(negedge clk);
      chk("b2b_busy5", {{(SIZE-1){1'b0}}, bus.done}, '0);
      @(negedge clk);                  // edge N+7: second result
      chk("b2b_done2", {{(SIZE-1){1'b0}}, bus.done}, {{(SIZE-1){1'b0}}, 1'b1});
      chk("b2b_result2", bus.result, {{(SIZE-4){1'b0}}, 4'd9});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
